imm_decode_pipe: RTL and testbench

//  Registered, handshaked immediate generator for the decode stage. It auto-decodes the

---
 rtl/imm_decode_pipe_if.sv | 33 +++
 rtl/imm_decode_pipe.sv | 163 ++++++++++++++++
 tb/tb_imm_decode_pipe.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_decode_pipe_if.sv
// imm_decode_pipe_if
//   Bundles the two handshake channels of the immediate decode stage.
//   Instruction channel: in_valid/in_ready, in_inst, in_tag, in_sel_ovr, in_immsel.
//   Result channel: out_valid/out_ready, out_imm, out_sel, out_illegal, out_tag.
//   master = upstream fetch and downstream consumer side; slave = the decode block.
interface imm_decode_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_inst;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  in_sel_ovr;
  logic [2:0]            in_immsel;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_imm;
  logic [2:0]            out_sel;
  logic                  out_illegal;
  logic [TAG_WIDTH-1:0]  out_tag;

  modport master (
    output in_valid, in_inst, in_tag, in_sel_ovr, in_immsel, out_ready,
    input  in_ready, out_valid, out_imm, out_sel, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_inst, in_tag, in_sel_ovr, in_immsel, out_ready,
    output in_ready, out_valid, out_imm, out_sel, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe
//   Registered, handshaked immediate generator for the decode stage. The format is
//   auto-decoded from the opcode or forced by an explicit format code, and the
//   extended immediate is emitted with the format code, an illegal flag and the
//   beat's tag. A one-entry output register plus a one-entry skid register keeps
//   in_ready a pure flop output, cutting the combinational ready path from decode
//   back to fetch.
// Ports
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active low
//   bus   : imm_decode_pipe_if.slave (instruction channel in, result channel out)
// Parameters
//   DATA_WIDTH : 32 or 64 (64 widens shamt to 6 bits)
//   TAG_WIDTH  : sideband width carried with each instruction
//   BJ_SCALED  : 1 keeps B/J immediates in halfword units, 0 shifts them left by one
module imm_decode_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32,
  parameter int BJ_SCALED  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  imm_decode_pipe_if.slave  bus
);

  localparam logic [2:0] SEL_NONE  = 3'b000;
  localparam logic [2:0] SEL_SHAMT = 3'b001;
  localparam logic [2:0] SEL_I     = 3'b010;
  localparam logic [2:0] SEL_S     = 3'b011;
  localparam logic [2:0] SEL_B     = 3'b100;
  localparam logic [2:0] SEL_J     = 3'b101;
  localparam logic [2:0] SEL_U     = 3'b110;
  localparam logic [2:0] SEL_SRA   = 3'b111;

  logic [31:0]           inst;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [2:0]            dec_sel;
  logic                  dec_illegal;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic [DATA_WIDTH-1:0] b_imm;
  logic [DATA_WIDTH-1:0] j_imm;

  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_imm_r;
  logic [2:0]            out_sel_r;
  logic                  out_illegal_r;
  logic [TAG_WIDTH-1:0]  out_tag_r;

  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_imm;
  logic [2:0]            skid_sel;
  logic                  skid_illegal;
  logic [TAG_WIDTH-1:0]  skid_tag;

  logic                  in_fire;
  logic                  out_free;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  // Format selection; i[30] splits srai from srli in the OP-IMM shift group.
  always_comb begin
    dec_sel     = SEL_NONE;
    dec_illegal = 1'b0;
    if (bus.in_sel_ovr) begin
      dec_sel = bus.in_immsel;
    end else begin
      case (opcode)
        7'b0010011: begin
          case (funct3)
            3'b001:  dec_sel = SEL_SHAMT;
            3'b101:  dec_sel = inst[30] ? SEL_SRA : SEL_SHAMT;
            default: dec_sel = SEL_I;
          endcase
        end
        7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: dec_sel = SEL_I;
        7'b0100011: dec_sel = SEL_S;
        7'b1100011: dec_sel = SEL_B;
        7'b1101111: dec_sel = SEL_J;
        7'b0110111, 7'b0010111: dec_sel = SEL_U;
        7'b0110011: dec_sel = SEL_NONE;
        default: begin
          dec_sel     = SEL_NONE;
          dec_illegal = 1'b1;
        end
      endcase
    end
  end

  // Size casts of signed operands sign-extend to DATA_WIDTH.
  always_comb begin
    b_imm = DATA_WIDTH'($signed({inst[31], inst[7], inst[30:25], inst[11:8]}));
    j_imm = DATA_WIDTH'($signed({inst[31], inst[19:12], inst[20], inst[30:21]}));
    if (BJ_SCALED == 0) begin
      b_imm = b_imm << 1;
      j_imm = j_imm << 1;
    end
    case (dec_sel)
      SEL_SHAMT, SEL_SRA: dec_imm = (DATA_WIDTH == 64) ? DATA_WIDTH'(inst[25:20])
                                                        : DATA_WIDTH'(inst[24:20]);
      SEL_I:   dec_imm = DATA_WIDTH'($signed(inst[31:20]));
      SEL_S:   dec_imm = DATA_WIDTH'($signed({inst[31:25], inst[11:7]}));
      SEL_B:   dec_imm = b_imm;
      SEL_J:   dec_imm = j_imm;
      SEL_U:   dec_imm = DATA_WIDTH'($signed({inst[31:12], 12'b0}));
      default: dec_imm = '0;
    endcase
  end

  assign in_fire  = bus.in_valid & ~skid_valid;
  assign out_free = ~out_valid_r | bus.out_ready;

  // Output register refills from the skid entry first so ordering stays FIFO;
  // a skid entry can only exist while the output is stalled, so in_ready is low
  // whenever the skid drains and no new beat can race it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r   <= 1'b0;
      out_imm_r     <= '0;
      out_sel_r     <= '0;
      out_illegal_r <= 1'b0;
      out_tag_r     <= '0;
      skid_valid    <= 1'b0;
      skid_imm      <= '0;
      skid_sel      <= '0;
      skid_illegal  <= 1'b0;
      skid_tag      <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid_r   <= 1'b1;
        out_imm_r     <= skid_imm;
        out_sel_r     <= skid_sel;
        out_illegal_r <= skid_illegal;
        out_tag_r     <= skid_tag;
        skid_valid    <= 1'b0;
      end else if (in_fire) begin
        out_valid_r   <= 1'b1;
        out_imm_r     <= dec_imm;
        out_sel_r     <= dec_sel;
        out_illegal_r <= dec_illegal;
        out_tag_r     <= bus.in_tag;
      end else begin
        out_valid_r   <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid   <= 1'b1;
      skid_imm     <= dec_imm;
      skid_sel     <= dec_sel;
      skid_illegal <= dec_illegal;
      skid_tag     <= bus.in_tag;
    end
  end

  assign bus.in_ready    = ~skid_valid;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_imm     = out_imm_r;
  assign bus.out_sel     = out_sel_r;
  assign bus.out_illegal = out_illegal_r;
  assign bus.out_tag     = out_tag_r;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// tb_imm_decode_pipe
//   Self-checking bench for imm_decode_pipe. Two instances share one stimulus
//   stream: an RV32 / BJ_SCALED=1 build and an RV64 / BJ_SCALED=0 build.
//   A behavioural model computes every expected immediate from the format rules
//   with plain integer arithmetic; a queue tracks beats held inside the block.
module tb_imm_decode_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_decode_pipe_if #(.DATA_WIDTH(32), .TAG_WIDTH(32)) bus32 ();
  imm_decode_pipe_if #(.DATA_WIDTH(64), .TAG_WIDTH(32)) bus64 ();

  assign bus64.in_valid   = bus32.in_valid;
  assign bus64.in_inst    = bus32.in_inst;
  assign bus64.in_tag     = bus32.in_tag;
  assign bus64.in_sel_ovr = bus32.in_sel_ovr;
  assign bus64.in_immsel  = bus32.in_immsel;
  assign bus64.out_ready  = bus32.out_ready;

  imm_decode_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(32), .BJ_SCALED(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32.slave)
  );

  imm_decode_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(32), .BJ_SCALED(0)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus64.slave)
  );

  int assert_count = 0;
  int fail_count   = 0;

  typedef struct {
    logic [2:0]  sel;
    logic        ill;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [31:0] tag;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic        ovr;
    logic [2:0]  isel;
    logic [2:0]  sel;
    logic        ill;
    logic [31:0] imm32;
    logic [63:0] imm64;
  } vec_t;

  exp_t scb[$];
  logic mon_on = 1'b0;
  vec_t vecs[15];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint sx(input longint f, input int n);
    longint half = longint'(1) << (n - 1);
    return (f >= half) ? f - (half << 1) : f;
  endfunction

  function automatic exp_t ref_model(input logic [31:0] i, input logic ovr,
                                     input logic [2:0] isel, input logic [31:0] tag);
    exp_t   e;
    longint v;
    longint v64;
    e.tag = tag;
    e.ill = 1'b0;
    e.sel = 3'b000;
    if (ovr) e.sel = isel;
    else begin
      case (i[6:0])
        7'h13: begin
          if (i[14:12] == 3'b001)      e.sel = 3'b001;
          else if (i[14:12] == 3'b101) e.sel = i[30] ? 3'b111 : 3'b001;
          else                         e.sel = 3'b010;
        end
        7'h03, 7'h67, 7'h73, 7'h0F: e.sel = 3'b010;
        7'h23:        e.sel = 3'b011;
        7'h63:        e.sel = 3'b100;
        7'h6F:        e.sel = 3'b101;
        7'h37, 7'h17: e.sel = 3'b110;
        7'h33:        e.sel = 3'b000;
        default:      e.ill = 1'b1;
      endcase
    end
    v   = 0;
    v64 = 0;
    case (e.sel)
      3'b001, 3'b111: begin v = longint'(i[24:20]); v64 = longint'(i[25:20]); end
      3'b010: begin v = sx(longint'(i[31:20]), 12); v64 = v; end
      3'b011: begin v = sx(longint'({i[31:25], i[11:7]}), 12); v64 = v; end
      3'b100: begin v = sx(longint'({i[31], i[7], i[30:25], i[11:8]}), 12); v64 = v * 2; end
      3'b101: begin v = sx(longint'({i[31], i[19:12], i[20], i[30:21]}), 20); v64 = v * 2; end
      3'b110: begin v = sx(longint'(i[31:12]), 20) * 4096; v64 = v; end
      default: begin v = 0; v64 = 0; end
    endcase
    e.imm32 = v[31:0];
    e.imm64 = v64;
    return e;
  endfunction

  // Scoreboard: occupancy predicts ready/valid, output fires pop in order.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      check_output("mon_in_ready",     64'(bus32.in_ready),  64'(scb.size() < 2));
      check_output("mon_out_valid",    64'(bus32.out_valid), 64'(scb.size() > 0));
      check_output("mon_out_valid64",  64'(bus64.out_valid), 64'(scb.size() > 0));
      if (!rst_n) begin
        scb.delete();
      end else begin
        if (bus32.out_valid && bus32.out_ready && scb.size() > 0) begin
          e = scb.pop_front();
          check_output("mon_tag",     64'(bus32.out_tag),     64'(e.tag));
          check_output("mon_sel",     64'(bus32.out_sel),     64'(e.sel));
          check_output("mon_illegal", 64'(bus32.out_illegal), 64'(e.ill));
          check_output("mon_imm32",   64'(bus32.out_imm),     64'(e.imm32));
          check_output("mon_imm64",   bus64.out_imm,          e.imm64);
          check_output("mon_tag64",   64'(bus64.out_tag),     64'(e.tag));
        end
        if (bus32.in_valid && bus32.in_ready)
          scb.push_back(ref_model(bus32.in_inst, bus32.in_sel_ovr, bus32.in_immsel, bus32.in_tag));
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] inst, input logic ovr,
                                input logic [2:0] isel, input logic [31:0] tag);
    int waits = 0;
    bus32.in_inst    = inst;
    bus32.in_sel_ovr = ovr;
    bus32.in_immsel  = isel;
    bus32.in_tag     = tag;
    bus32.in_valid   = 1'b1;
    while (!bus32.in_ready && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= 20) begin
      assert_count++;
      fail_count++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rinst;
    logic [6:0]  ops[12];
    logic        acc;
    logic [31:0] got[$];

    vecs[0]  = '{32'hFFF00093, 1'b0, 3'd0, 3'b010, 1'b0, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};
    vecs[1]  = '{32'h4030D093, 1'b0, 3'd0, 3'b111, 1'b0, 32'h00000003, 64'h3};
    vecs[2]  = '{32'h43F0D093, 1'b0, 3'd0, 3'b111, 1'b0, 32'h0000001F, 64'h3F};
    vecs[3]  = '{32'hFE000EE3, 1'b0, 3'd0, 3'b100, 1'b0, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFFC};
    vecs[4]  = '{32'h12345037, 1'b0, 3'd0, 3'b110, 1'b0, 32'h12345000, 64'h00000000_12345000};
    vecs[5]  = '{32'h80000037, 1'b0, 3'd0, 3'b110, 1'b0, 32'h80000000, 64'hFFFFFFFF_80000000};
    vecs[6]  = '{32'h0000007F, 1'b0, 3'd0, 3'b000, 1'b1, 32'h0,        64'h0};
    vecs[7]  = '{32'h0000007F, 1'b1, 3'd2, 3'b010, 1'b0, 32'h0,        64'h0};
    vecs[8]  = '{32'hFE112E23, 1'b0, 3'd0, 3'b011, 1'b0, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC};
    vecs[9]  = '{32'h0080006F, 1'b0, 3'd0, 3'b101, 1'b0, 32'h00000004, 64'h8};
    vecs[10] = '{32'h00309093, 1'b0, 3'd0, 3'b001, 1'b0, 32'h00000003, 64'h3};
    vecs[11] = '{32'h002081B3, 1'b0, 3'd0, 3'b000, 1'b0, 32'h0,        64'h0};
    vecs[12] = '{32'hFFFFF0FF, 1'b1, 3'd6, 3'b110, 1'b0, 32'hFFFFF000, 64'hFFFFFFFF_FFFFF000};
    vecs[13] = '{32'h0080006F, 1'b1, 3'd5, 3'b101, 1'b0, 32'h00000004, 64'h8};
    vecs[14] = '{32'hFFFFFFFF, 1'b1, 3'd0, 3'b000, 1'b0, 32'h0,        64'h0};

    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h13};

    rst_n            = 1'b0;
    bus32.in_valid   = 1'b1;
    bus32.in_inst    = 32'hFFF00093;
    bus32.in_tag     = 32'hDEAD;
    bus32.in_sel_ovr = 1'b0;
    bus32.in_immsel  = 3'd0;
    bus32.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_out_valid", 64'(bus32.out_valid), 64'd0);
    check_output("rst_in_ready",  64'(bus32.in_ready),  64'd1);
    check_output("rst_out_imm",   64'(bus32.out_imm),   64'd0);
    check_output("rst_out_sel",   64'(bus32.out_sel),   64'd0);
    check_output("rst_out_ill",   64'(bus32.out_illegal), 64'd0);
    check_output("rst_out_tag",   64'(bus32.out_tag),   64'd0);
    check_output("rst_out_imm64", bus64.out_imm,        64'd0);
    bus32.in_valid = 1'b0;
    rst_n  = 1'b1;
    mon_on = 1'b1;

    $display("[TB] table-driven vectors");
    for (int k = 0; k < 15; k++) begin
      apply_stimulus(vecs[k].inst, vecs[k].ovr, vecs[k].isel, 32'h100 + k);
      check_output($sformatf("vec%0d_valid", k), 64'(bus32.out_valid),   64'd1);
      check_output($sformatf("vec%0d_sel", k),   64'(bus32.out_sel),     64'(vecs[k].sel));
      check_output($sformatf("vec%0d_ill", k),   64'(bus32.out_illegal), 64'(vecs[k].ill));
      check_output($sformatf("vec%0d_imm32", k), 64'(bus32.out_imm),     64'(vecs[k].imm32));
      check_output($sformatf("vec%0d_imm64", k), bus64.out_imm,          vecs[k].imm64);
      check_output($sformatf("vec%0d_tag", k),   64'(bus32.out_tag),     64'(32'h100 + k));
    end
    @(posedge clk); #1;

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      rinst = $urandom;
      if ($urandom_range(0, 9) != 0) rinst[6:0] = ops[$urandom_range(0, 11)];
      bus32.in_inst    = rinst;
      bus32.in_tag     = $urandom;
      bus32.in_sel_ovr = ($urandom_range(0, 3) == 0);
      bus32.in_immsel  = 3'($urandom_range(0, 7));
      bus32.in_valid   = ($urandom_range(0, 3) != 0);
      bus32.out_ready  = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    rst_n           = 1'b1;
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_output("drain_empty", 64'(bus32.out_valid), 64'd0);

    $display("[TB] stall with skid fill");
    bus32.in_inst    = 32'hFFF00093;
    bus32.in_sel_ovr = 1'b0;
    bus32.out_ready  = 1'b0;
    bus32.in_valid   = 1'b1;
    bus32.in_tag     = 32'd1;
    @(posedge clk); #1;
    bus32.in_tag = 32'd2;
    @(posedge clk); #1;
    bus32.in_tag = 32'd3;
    check_output("t4_out_tag",   64'(bus32.out_tag),   64'd1);
    check_output("t4_out_valid", 64'(bus32.out_valid), 64'd1);
    check_output("t4_in_ready",  64'(bus32.in_ready),  64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_output("t4_held_tag",  64'(bus32.out_tag),   64'd1);
    check_output("t4_held_rdy",  64'(bus32.in_ready),  64'd0);
    bus32.out_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus32.out_valid && bus32.out_ready) got.push_back(bus32.out_tag);
      acc = bus32.in_valid && bus32.in_ready;
      @(posedge clk); #1;
      if (acc) bus32.in_valid = 1'b0;
    end
    check_output("t4_count", 64'(got.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      check_output($sformatf("t4_order%0d", k),
                   (got.size() > k) ? 64'(got[k]) : 64'hFFFF, 64'(k + 1));

    $display("[TB] reset with both stages full");
    bus32.out_ready = 1'b0;
    bus32.in_valid  = 1'b1;
    bus32.in_tag    = 32'd10;
    @(posedge clk); #1;
    bus32.in_tag = 32'd11;
    @(posedge clk); #1;
    bus32.in_tag = 32'd12;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_output("t6_out_valid", 64'(bus32.out_valid), 64'd0);
    check_output("t6_in_ready",  64'(bus32.in_ready),  64'd1);
    check_output("t6_out_tag",   64'(bus32.out_tag),   64'd0);
    rst_n           = 1'b1;
    bus32.in_tag    = 32'd20;
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    check_output("t6_first_valid", 64'(bus32.out_valid), 64'd1);
    check_output("t6_first_tag",   64'(bus32.out_tag),   64'd20);
    check_output("t6_first_imm",   64'(bus32.out_imm),   64'hFFFFFFFF);
    @(posedge clk); #1;
    check_output("t6_alone", 64'(bus32.out_valid), 64'd0);

    @(posedge clk); #1;
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
